// File: rtl/dvbc_pkg.sv
// Shared definitions for the DVB-C SRRC polyphase filter controller.
// FSM encoding, default sizing and a width helper used by the controller and its tap counter.
package dvbc_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OSR    = 4;
  localparam int DEF_NTAPS  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Never returns 0 so a single-entry counter or address still gets a 1-bit register.
  function automatic int clog2(input int value);
    int r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dvbc_srrc_tapcnt.sv
// Phase/tap counter pair for the polyphase SRRC controller.
// Tap wraps every NTAPS steps; phase advances on its own step strobe; clr zeroes both.
module dvbc_srrc_tapcnt
  import dvbc_pkg::*;
#(
  parameter  int OSR   = DEF_OSR,
  parameter  int NTAPS = DEF_NTAPS,
  localparam int TW    = clog2(NTAPS),
  localparam int PW    = clog2(OSR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          tap_step,
  input  logic          phase_step,
  output logic [TW-1:0] tap,
  output logic [PW-1:0] phase,
  output logic          tap_last,
  output logic          phase_last
);

  assign tap_last   = (tap == TW'(NTAPS - 1));
  assign phase_last = (phase == PW'(OSR - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap   <= '0;
      phase <= '0;
    end else if (clr) begin
      tap   <= '0;
      phase <= '0;
    end else begin
      if (tap_step)   tap   <= tap_last ? '0 : tap + TW'(1);
      if (phase_step) phase <= phase_last ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/dvbc_srrc_ctrl.sv
// Sequencer for a polyphase SRRC interpolator: loads one symbol, runs OSR MAC passes, emits OSR samples.
// Optional sticky-starvation counter port uflow_cnt_o is built when DVBC_SRRC_CTRL_UFLOW_CNT_EN is defined.
module dvbc_srrc_ctrl
  import dvbc_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int OSR    = DEF_OSR,
  parameter  int NTAPS  = DEF_NTAPS,
  localparam int CW     = clog2(OSR * NTAPS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                sym_valid_i,
  input  logic [2*DATA_W-1:0] sym_data_i,
  output logic                sym_ready_o,
  output logic                shift_en_o,
  output logic [2*DATA_W-1:0] shift_data_o,
  output logic [CW-1:0]       coef_addr_o,
  output logic                acc_clr_o,
  output logic                acc_en_o,
  output logic                smp_valid_o,
  input  logic                smp_ready_i,
  output logic                busy_o,
  output logic                underflow_o,
  output logic [1:0]          dbg_state_o
`ifdef DVBC_SRRC_CTRL_UFLOW_CNT_EN
  ,
  output logic [15:0]         uflow_cnt_o
`endif
);

  localparam int TW = clog2(NTAPS);
  localparam int PW = clog2(OSR);

  state_t        state;
  logic [TW-1:0] tap;
  logic [PW-1:0] phase;
  logic          tap_last;
  logic          phase_last;
  logic          cnt_clr;
  logic          tap_step;
  logic          phase_step;

  // Handshakes: the symbol is taken in the single LOAD cycle regardless of sym_valid_i (a missing
  // symbol becomes zero); a sample transfers on a cycle where smp_valid_o && smp_ready_i, and
  // smp_valid_o stays high until that cycle.
  assign cnt_clr    = (state == LOAD);
  assign tap_step   = (state == MAC);
  assign phase_step = (state == OUT) && smp_ready_i && !phase_last;

  dvbc_srrc_tapcnt #(
    .OSR   (OSR),
    .NTAPS (NTAPS)
  ) u_tapcnt (
    .clk        (clk_i),
    .rst        (rst_i),
    .clr        (cnt_clr),
    .tap_step   (tap_step),
    .phase_step (phase_step),
    .tap        (tap),
    .phase      (phase),
    .tap_last   (tap_last),
    .phase_last (phase_last)
  );

`ifdef DVBC_SRRC_CTRL_UFLOW_CNT_EN
  logic [15:0] uflow_cnt;
  assign uflow_cnt_o = uflow_cnt;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      underflow_o <= 1'b0;
`ifdef DVBC_SRRC_CTRL_UFLOW_CNT_EN
      uflow_cnt   <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: if (enable_i) state <= LOAD;
        LOAD: begin
          state <= MAC;
          if (!sym_valid_i) begin
            underflow_o <= 1'b1;
`ifdef DVBC_SRRC_CTRL_UFLOW_CNT_EN
            if (uflow_cnt != 16'hFFFF) uflow_cnt <= uflow_cnt + 16'd1;
`endif
          end
        end
        MAC: if (tap_last) state <= OUT;
        OUT: begin
          // enable_i is only looked at on the symbol boundary so a period is never cut short.
          if (smp_ready_i) begin
            if (!phase_last)   state <= MAC;
            else if (enable_i) state <= LOAD;
            else               state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode the state register directly, so an asynchronous reset clears them at once.
  assign busy_o       = (state != IDLE);
  assign sym_ready_o  = (state == LOAD);
  assign shift_en_o   = (state == LOAD);
  assign shift_data_o = (state == LOAD && sym_valid_i) ? sym_data_i : '0;
  assign acc_en_o     = (state == MAC);
  assign acc_clr_o    = (state == MAC) && (tap == '0);
  assign smp_valid_o  = (state == OUT);
  assign coef_addr_o  = (state == MAC) ? CW'(32'(phase) * NTAPS + 32'(tap)) : '0;
  assign dbg_state_o  = state;

endmodule

// File: doc/dvbc_srrc_ctrl.md
DVBC_SRRC_CTRL -- requirements
Module: dvbc_srrc_ctrl

Interface
REQ-001 Parameters SHALL be as follows.
- DATA_W, default 8: width of each I and Q symbol component.
- OSR, default 4: output samples per symbol.
- NTAPS, default 8: filter taps per polyphase branch.
REQ-002 Ports SHALL be as follows (name  direction  width  meaning).
- clk_i  in  1  the single clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  run request.
- sym_valid_i  in  1  mapper symbol valid.
- sym_data_i  in  2*DATA_W  symbol as {I,Q}.
- sym_ready_o  out  1  symbol accepted this cycle.
- shift_en_o  out  1  shift the filter delay line.
- shift_data_o  out  2*DATA_W  value shifted in.
- coef_addr_o  out  clog2(OSR*NTAPS)  coefficient ROM address.
- acc_clr_o  out  1  clear the filter accumulator.
- acc_en_o  out  1  accumulate this cycle.
- smp_valid_o  out  1  filter output sample valid.
- smp_ready_i  in  1  downstream accepts the sample.
- busy_o  out  1  FSM is not in IDLE.
- underflow_o  out  1  sticky symbol-starvation flag.
REQ-003 clk_i SHALL be the only clock; rst_i SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have four states: IDLE, LOAD, MAC and OUT.
REQ-005 IDLE: all strobes SHALL be low; the FSM SHALL go to LOAD in the cycle after enable_i is sampled high.
REQ-006 LOAD SHALL last exactly 1 cycle.
- shift_en_o=1 and sym_ready_o=1.
- sym_valid_i=1: shift_data_o=sym_data_i.
- sym_valid_i=0: shift_data_o=0 (zero-symbol insertion) and underflow_o is set.
- The phase counter is cleared; next state is MAC.
REQ-007 MAC SHALL last exactly NTAPS cycles.
- acc_en_o=1 every cycle.
- acc_clr_o=1 only when tap==0.
- coef_addr_o=phase*NTAPS+tap.
- At tap==NTAPS-1 the tap counter wraps to 0 and the next state is OUT.
REQ-008 OUT: smp_valid_o SHALL stay high until smp_ready_i=1; smp_valid_o SHALL never drop without a handshake.
REQ-009 On the OUT handshake the next state SHALL be:
- phase<OSR-1: phase increments and the next state is MAC.
- phase==OSR-1 and enable_i=1: LOAD.
- phase==OSR-1 and enable_i=0: IDLE.
REQ-010 enable_i deasserted mid-period SHALL NOT abort; the current symbol period completes, then the FSM returns to IDLE.
REQ-011 Latency and period:
- First smp_valid_o SHALL assert NTAPS+1 cycles after the LOAD cycle.
- With smp_ready_i held high, a symbol period SHALL be OSR*(NTAPS+1)+1 cycles (37 at defaults).
REQ-012 coef_addr_o SHALL be 0 outside MAC; shift_data_o SHALL be 0 outside LOAD.
REQ-013 busy_o SHALL be 1 in every state except IDLE.
REQ-014 underflow_o SHALL be cleared only by reset.

Reset
REQ-015 While rst_i=1 the block SHALL hold as follows.
- FSM in IDLE; phase and tap counters at 0.
- All outputs 0, including underflow_o and the underflow counter.
REQ-016 When rst_i asserts mid-operation, the block SHALL drop all strobes immediately (asynchronously) and SHALL restart only through IDLE.

Configuration
REQ-017 With DVBC_SRRC_CTRL_UFLOW_CNT_EN defined:
- an extra output uflow_cnt_o[15:0] SHALL count zero-inserted LOAD cycles;
- the counter saturates at 16'hFFFF and resets to 0.
REQ-018 With DVBC_SRRC_CTRL_UFLOW_CNT_EN undefined, the port and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-019 Package dvbc_pkg SHALL hold:
- the FSM state encoding (IDLE=0, LOAD=1, MAC=2, OUT=3);
- the default DATA_W, OSR and NTAPS constants;
- a clog2 function.
REQ-020 The phase/tap counter pair SHALL be a sub-module, dvbc_srrc_tapcnt, providing clear, step, tap wrap and phase-last indications.

Verification
REQ-021 Steady state: enable_i=1, sym_valid_i=1, smp_ready_i=1 -> LOAD repeats every 37 cycles; coef_addr_o sequences 0..31 per symbol; 4 samples per symbol.
REQ-022 Starvation: sym_valid_i=0 at LOAD -> shift_data_o=0, underflow_o=1 from the next cycle; with the macro defined, uflow_cnt_o=1.
REQ-023 Backpressure: smp_ready_i=0 for 5 cycles in OUT at phase 2 -> smp_valid_o held for 6 cycles; coef_addr_o resumes at 24.
REQ-024 Graceful stop: enable_i dropped during phase 1 -> phases 1 to 3 complete, then IDLE; busy_o=0 and no further sym_ready_o.
REQ-025 Reset mid-MAC (tap 5) -> all outputs 0 asynchronously; after release, with enable_i=1, the first LOAD occurs 1 cycle later.
REQ-026 NTAPS=1, OSR=2 -> symbol period of 5 cycles; acc_clr_o and acc_en_o are high together in every MAC cycle.
